// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: forwarding-select encodings,
// the PC register index and the register-address width.
package core_pkg;

  localparam int RADDR_W = 4;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [3:0] REG_PC = 4'd15;

  // M-stage hit outranks W-stage hit: M holds the younger write.
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the stall/flush debug counters; holds at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding unit for the 5-stage core: tracks destination registers
// D->E->M->W and produces stall, flush and operand-forwarding selects.
module hazard_unit
  import core_pkg::*;
#(
  parameter int RADDR_W = core_pkg::RADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RADDR_W-1:0] RA1D,
  input  logic [RADDR_W-1:0] RA2D,
  input  logic [RADDR_W-1:0] WA3D,
  input  logic               RegWriteD,
  input  logic               PCSrcD,
  input  logic               PCSrcE,
  input  logic               PCSrcM,
  input  logic               PCSrcW,
  input  logic               RegWriteE,
  input  logic               RegWriteM,
  input  logic               RegWriteW,
  input  logic               MemToRegE,
  input  logic               BranchTakenE,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE,
  output logic               StallF,
  output logic               StallD,
  output logic               FlushD,
  output logic               FlushE,
  output logic [CNT_W-1:0]   StallCnt,
  output logic [CNT_W-1:0]   FlushCnt
);

  localparam logic [RADDR_W-1:0] PC_ADDR = RADDR_W'(REG_PC);

  logic [RADDR_W-1:0] ra1e_q, ra1e_d, ra2e_q, ra2e_d, wa3e_q, wa3e_d;
  logic [RADDR_W-1:0] wa3m_q, wa3w_q;
  logic               ve_q, ve_d, vm_q, vw_q;

  logic ldr_stall, pc_wr_pending;
  logic hit_am, hit_aw, hit_bm, hit_bw;

  assign ldr_stall = ve_q & RegWriteE & MemToRegE &
                     ((RA1D == wa3e_q) | (RA2D == wa3e_q));
  assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

  // R15 reads are served by the datapath, so it never matches a forward.
  assign hit_am = vm_q & RegWriteM & (ra1e_q == wa3m_q) & (ra1e_q != PC_ADDR);
  assign hit_aw = vw_q & RegWriteW & (ra1e_q == wa3w_q) & (ra1e_q != PC_ADDR);
  assign hit_bm = vm_q & RegWriteM & (ra2e_q == wa3m_q) & (ra2e_q != PC_ADDR);
  assign hit_bw = vw_q & RegWriteW & (ra2e_q == wa3w_q) & (ra2e_q != PC_ADDR);

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    if (!reset) begin
      ForwardAE = fwd_sel(hit_am, hit_aw);
      ForwardBE = fwd_sel(hit_bm, hit_bw);
      StallF    = ldr_stall | pc_wr_pending;
      StallD    = ldr_stall;
      FlushD    = pc_wr_pending | PCSrcW | BranchTakenE;
      FlushE    = ldr_stall | BranchTakenE;
    end
  end

  // A flushed E slot becomes a bubble that can never forward or stall.
  always_comb begin
    ra1e_d = RA1D;
    ra2e_d = RA2D;
    wa3e_d = WA3D;
    ve_d   = RegWriteD & (WA3D != PC_ADDR);
    if (FlushE) begin
      ra1e_d = '0;
      ra2e_d = '0;
      wa3e_d = '0;
      ve_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ra1e_q <= '0;
      ra2e_q <= '0;
      wa3e_q <= '0;
      ve_q   <= 1'b0;
      wa3m_q <= '0;
      vm_q   <= 1'b0;
      wa3w_q <= '0;
      vw_q   <= 1'b0;
    end else begin
      ra1e_q <= ra1e_d;
      ra2e_q <= ra2e_d;
      wa3e_q <= wa3e_d;
      ve_q   <= ve_d;
      wa3m_q <= wa3e_q;
      vm_q   <= ve_q;
      wa3w_q <= wa3m_q;
      vw_q   <= vm_q;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallD & ~reset),
    .count (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushE & ~reset),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding priority, load-use stall, branch
// flush, PC-write walk, R15 exclusion, counter saturation and mid-stall reset.
module tb_hazard_unit;

  localparam int RW = 4;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [RW-1:0] RA1D, RA2D, WA3D;
  logic          RegWriteD;
  logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic          RegWriteE, RegWriteM, RegWriteW;
  logic          MemToRegE, BranchTakenE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, FlushD, FlushE;
  logic [CW-1:0] StallCnt, FlushCnt;

  int tests = 0;
  int fails = 0;

  hazard_unit #(.RADDR_W(RW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3D         (WA3D),
    .RegWriteD    (RegWriteD),
    .PCSrcD       (PCSrcD),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCSrcW       (PCSrcW),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemToRegE    (MemToRegE),
    .BranchTakenE (BranchTakenE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RA1D = '0; RA2D = '0; WA3D = '0; RegWriteD = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemToRegE = 1'b0; BranchTakenE = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state: outputs forced regardless of hazard-looking inputs.
    reset = 1'b1;
    idle();
    RegWriteE = 1'b1; MemToRegE = 1'b1; PCSrcD = 1'b1;
    #2;
    chk("rst_stallf", 16'(StallF), 16'd0);
    chk("rst_stalld", 16'(StallD), 16'd0);
    chk("rst_flushd", 16'(FlushD), 16'd1);
    chk("rst_flushe", 16'(FlushE), 16'd1);
    chk("rst_fwda",   16'(ForwardAE), 16'd0);
    tick();
    chk("rst_stallcnt", 16'(StallCnt), 16'd0);
    chk("rst_flushcnt", 16'(FlushCnt), 16'd0);
    reset = 1'b0;
    idle();
    #1;
    chk("quiet_flushd", 16'(FlushD), 16'd0);
    chk("quiet_stallf", 16'(StallF), 16'd0);

    // ADD R1 in M, consumer in E reads R1 on operand A.
    do_reset();
    RegWriteD = 1'b1; WA3D = 4'd1;
    tick();
    RegWriteD = 1'b0; WA3D = 4'd0; RA1D = 4'd1; RA2D = 4'd0;
    tick();
    idle();
    RegWriteM = 1'b1;
    #1;
    chk("fwd_m_a", 16'(ForwardAE), 16'(2'b10));
    chk("fwd_m_b", 16'(ForwardBE), 16'(2'b00));
    RegWriteM = 1'b0;
    #1;
    chk("fwd_m_gated", 16'(ForwardAE), 16'(2'b00));

    // R2 written in both M and W: M wins; W takes over when M not writing.
    do_reset();
    RegWriteD = 1'b1; WA3D = 4'd2;
    tick();
    tick();
    RegWriteD = 1'b0; WA3D = 4'd0; RA2D = 4'd2;
    tick();
    idle();
    RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1;
    chk("fwd_mw_b", 16'(ForwardBE), 16'(2'b10));
    chk("fwd_mw_a", 16'(ForwardAE), 16'(2'b00));
    RegWriteM = 1'b0;
    #1;
    chk("fwd_w_b", 16'(ForwardBE), 16'(2'b01));

    // Same, but the younger R2 write is squashed by a branch flush.
    do_reset();
    RegWriteD = 1'b1; WA3D = 4'd2;
    tick();
    BranchTakenE = 1'b1;
    #1;
    chk("sq_flushe", 16'(FlushE), 16'd1);
    tick();
    BranchTakenE = 1'b0; RegWriteD = 1'b0; WA3D = 4'd0; RA2D = 4'd2;
    tick();
    idle();
    RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1;
    chk("fwd_after_flush_b", 16'(ForwardBE), 16'(2'b01));

    // LDR R3 in E, dependent in D via RA1 then via RA2.
    do_reset();
    RegWriteD = 1'b1; WA3D = 4'd3;
    tick();
    RegWriteD = 1'b0; WA3D = 4'd0; RA1D = 4'd3; RegWriteE = 1'b1; MemToRegE = 1'b1;
    #1;
    chk("ldr_stallf", 16'(StallF), 16'd1);
    chk("ldr_stalld", 16'(StallD), 16'd1);
    chk("ldr_flushe", 16'(FlushE), 16'd1);
    chk("ldr_flushd", 16'(FlushD), 16'd0);
    tick();
    chk("ldr_drop_stalld", 16'(StallD), 16'd0);
    chk("ldr_drop_stallf", 16'(StallF), 16'd0);
    chk("ldr_drop_flushe", 16'(FlushE), 16'd0);
    chk("ldr_stallcnt", 16'(StallCnt), 16'd1);
    chk("ldr_flushcnt", 16'(FlushCnt), 16'd1);
    RegWriteD = 1'b1; WA3D = 4'd3; RA1D = 4'd0;
    tick();
    RegWriteD = 1'b0; WA3D = 4'd0; RA2D = 4'd3;
    #1;
    chk("ldr_rb_stalld", 16'(StallD), 16'd1);
    tick();
    chk("ldr_rb_stallcnt", 16'(StallCnt), 16'd2);

    // Taken branch squashes the D->E transfer of an R5 writer.
    do_reset();
    RegWriteD = 1'b1; WA3D = 4'd5; BranchTakenE = 1'b1;
    #1;
    chk("br_flushd", 16'(FlushD), 16'd1);
    chk("br_flushe", 16'(FlushE), 16'd1);
    chk("br_stalld", 16'(StallD), 16'd0);
    tick();
    idle();
    RA1D = 4'd5;
    #1;
    chk("br_flushcnt", 16'(FlushCnt), 16'd1);
    chk("br_flushe_drop", 16'(FlushE), 16'd0);
    tick();
    idle();
    RegWriteM = 1'b1;
    #1;
    chk("br_no_fwd", 16'(ForwardAE), 16'(2'b00));

    // PC write walking D -> E -> M -> W, then gone.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      PCSrcD = (i == 0);
      PCSrcE = (i == 1);
      PCSrcM = (i == 2);
      PCSrcW = (i == 3);
      #1;
      chk($sformatf("pc_stallf_%0d", i), 16'(StallF), 16'(i < 3));
      chk($sformatf("pc_flushd_%0d", i), 16'(FlushD), 16'(i < 4));
      chk($sformatf("pc_flushe_%0d", i), 16'(FlushE), 16'd0);
      tick();
    end

    // Write to R15 never forwards.
    do_reset();
    RegWriteD = 1'b1; WA3D = 4'd15;
    tick();
    RegWriteD = 1'b0; WA3D = 4'd0; RA1D = 4'd15;
    tick();
    idle();
    RegWriteM = 1'b1;
    #1;
    chk("r15_no_fwd", 16'(ForwardAE), 16'(2'b00));

    // Repeated load-use: stall every other cycle, 20 stalls over 40 edges.
    do_reset();
    RegWriteD = 1'b1; WA3D = 4'd3; RA1D = 4'd3; RegWriteE = 1'b1; MemToRegE = 1'b1;
    repeat (28) tick();
    chk("sat_stall_14", 16'(StallCnt), 16'd14);
    chk("sat_flush_14", 16'(FlushCnt), 16'd14);
    repeat (2) tick();
    chk("sat_stall_15", 16'(StallCnt), 16'd15);
    repeat (10) tick();
    chk("sat_stall_hold", 16'(StallCnt), 16'd15);
    chk("sat_flush_hold", 16'(FlushCnt), 16'd15);
    chk("sat_even_nostall", 16'(StallD), 16'd0);

    // Reset lands while an R3 load is entering E.
    reset = 1'b1;
    #1;
    chk("midrst_stalld", 16'(StallD), 16'd0);
    chk("midrst_flushe", 16'(FlushE), 16'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_stallcnt", 16'(StallCnt), 16'd0);
    chk("midrst_flushcnt", 16'(FlushCnt), 16'd0);
    chk("midrst_valid_clr", 16'(StallD), 16'd0);
    tick();
    chk("midrst_recover", 16'(StallD), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
